// File: rtl/rr_grant_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_ctrl
// Description : Round-robin grant controller sharing one single-user resource
//               among N level requesters. Registered one-hot grant, bounded
//               hold time, one idle gap cycle between consecutive grants.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_ctrl #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic [N-1:0]                         req,
  output logic [N-1:0]                         gnt,
  output logic                                 gnt_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id,
  output logic                                 timeout
);

  localparam int             c_IW        = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0]     c_HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [c_IW-1:0]   ptr_q, ptr_d;
  logic [c_IW-1:0]   win_q, win_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [c_IW-1:0]   gnt_id_q, gnt_id_d;
  logic              timeout_q, timeout_d;
  logic [c_IW-1:0]   sel_idx;
  logic              any_req;

  // Index arithmetic modulo N; handles N that is not a power of two.
  function automatic logic [c_IW-1:0] wrap_idx(input logic [c_IW-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(N)) s = s - 32'(N);
    return c_IW'(s);
  endfunction

  function automatic logic [N-1:0] onehot(input logic [c_IW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign any_req = |req;

  // Pick the first requester at or after ptr; scanned from the far end so the
  // closest one to ptr is assigned last and wins.
  always_comb begin
    sel_idx = ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_idx(ptr_q, unsigned'(k))]) sel_idx = wrap_idx(ptr_q, unsigned'(k));
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // every output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = '0;
    gnt_valid_d = 1'b0;
    gnt_id_d    = gnt_id_q;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (en && any_req) begin
          state_d     = ST_GRANT;
          win_d       = sel_idx;
          hold_cnt_d  = 8'd0;
          gnt_d       = onehot(sel_idx);
          gnt_valid_d = 1'b1;
          gnt_id_d    = sel_idx;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A dropped request is a normal release even on the last allowed cycle.
        if (!req[win_q]) begin
          state_d = ST_GAP;
          ptr_d   = wrap_idx(win_q, 1);
        end else if (hold_cnt_q == c_HOLD_LAST) begin
          state_d   = ST_GAP;
          ptr_d     = wrap_idx(win_q, 1);
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d  = hold_cnt_q + 8'd1;
          gnt_d       = onehot(win_q);
          gnt_valid_d = 1'b1;
          gnt_id_d    = win_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      hold_cnt_q  <= 8'd0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire
